// File: rtl/cmd_sequencer_pkg.sv
// Shared types and constants for the SD CMD-line sequencer: state encoding,
// status codes, command frame field positions and the CRC7 polynomial.
package cmd_seq_pkg;

  localparam int FRAME_W = 48;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_CRC      = 3'd1;
  localparam logic [2:0] ST_SEND     = 3'd2;
  localparam logic [2:0] ST_WAIT_RSP = 3'd3;
  localparam logic [2:0] ST_CHECK    = 3'd4;
  localparam logic [2:0] ST_DONE     = 3'd5;

  typedef enum logic [2:0] {
    STAT_OK        = 3'd0,
    STAT_TIMEOUT   = 3'd1,
    STAT_CRC_ERR   = 3'd2,
    STAT_INDEX_ERR = 3'd3,
    STAT_WATCHDOG  = 3'd4
  } status_e;

  localparam int FRM_START  = 47;
  localparam int FRM_TX     = 46;
  localparam int FRM_IDX_HI = 45;
  localparam int FRM_IDX_LO = 40;
  localparam int FRM_ARG_HI = 39;
  localparam int FRM_ARG_LO = 8;
  localparam int FRM_CRC_HI = 7;
  localparam int FRM_CRC_LO = 1;
  localparam int FRM_END    = 0;

  localparam logic [6:0] CRC7_POLY = 7'h09;
  localparam logic [5:0] CRC_BITS  = 6'd40;

  function automatic logic [FRAME_W-1:0] build_frame(input logic [5:0]  idx,
                                                     input logic [31:0] arg);
    logic [FRAME_W-1:0] f;
    f = '0;
    f[FRM_START]                 = 1'b0;
    f[FRM_TX]                    = 1'b1;
    f[FRM_IDX_HI:FRM_IDX_LO]     = idx;
    f[FRM_ARG_HI:FRM_ARG_LO]     = arg;
    f[FRM_END]                   = 1'b1;
    return f;
  endfunction

endpackage

// File: rtl/cmd_sequencer_if.sv
// Handshake bundle between cmd_sequencer (master) and physic_block_control (slave).
interface cmd_sequencer_if;
  import cmd_seq_pkg::*;

  logic [FRAME_W-1:0] oPhy_command;
  logic               oPhy_strobe;
  logic               iPhy_ack;
  logic               iPhy_strobe;
  logic [FRAME_W-1:0] iPhy_response;
  logic               iPhy_timeout;
  logic               oPhy_ack;
  logic               oPhy_idle;

  modport master (
    output oPhy_command, oPhy_strobe, oPhy_ack, oPhy_idle,
    input  iPhy_ack, iPhy_strobe, iPhy_response, iPhy_timeout
  );

  modport slave (
    input  oPhy_command, oPhy_strobe, oPhy_ack, oPhy_idle,
    output iPhy_ack, iPhy_strobe, iPhy_response, iPhy_timeout
  );

endinterface

// File: rtl/cmd_sequencer_crc7.sv
// Serial CRC7 engine (x^7+x^3+1, init 0), one message bit per enabled cycle, MSB first.
module cmd_crc7
  import cmd_seq_pkg::*;
(
  input  logic       iClock_SD,
  input  logic       iReset,
  input  logic       clear_i,
  input  logic       shift_i,
  input  logic       data_i,
  output logic [6:0] crc_o
);

  logic [6:0] crc_q;
  logic [6:0] crc_d;
  logic       fb;

  always_comb begin
    fb    = data_i ^ crc_q[6];
    crc_d = crc_q;
    if (clear_i) begin
      crc_d = '0;
    end else if (shift_i) begin
      crc_d = {crc_q[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'd0);
    end
  end

  always_ff @(posedge iClock_SD or posedge iReset) begin
    if (iReset) begin
      crc_q <= '0;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc_o = crc_q;

endmodule

// File: rtl/cmd_sequencer.sv
// SD CMD-line sequencer: frame build + CRC7, PHY handshake, response capture and retry.
// Response CRC/index checking is present only when CMD_RSP_CHECK_EN is defined.
module cmd_sequencer
  import cmd_seq_pkg::*;
#(
  parameter int MAX_RETRIES     = 2,
  parameter int WATCHDOG_CYCLES = 4096
) (
  input  logic               iClock_SD,
  input  logic               iReset,
  input  logic               iNew_command,
  input  logic [5:0]         iCmd_index,
  input  logic [31:0]        iCmd_argument,
  input  logic               iRsp_expected,
  output logic               oBusy,
  output logic               oDone,
  output logic [2:0]         oStatus,
  output logic [FRAME_W-1:0] oResponse,
  cmd_sequencer_if.master    phy
);

  localparam logic [2:0]  MAX_R   = 3'(MAX_RETRIES);
  localparam logic [15:0] WD_LAST = 16'(WATCHDOG_CYCLES - 1);

  logic [2:0]         state_q,    state_d;
  logic [FRAME_W-1:0] frame_q,    frame_d;
  logic [39:0]        sh_q,       sh_d;
  logic [5:0]         bit_cnt_q,  bit_cnt_d;
  logic [2:0]         retry_q,    retry_d;
  logic [15:0]        wd_q,       wd_d;
  logic               rsp_exp_q,  rsp_exp_d;
  logic               busy_q,     busy_d;
  logic               done_q,     done_d;
  logic [2:0]         status_q,   status_d;
  logic [FRAME_W-1:0] response_q, response_d;
  logic               strobe_q,   strobe_d;
  logic               phy_ack_q,  phy_ack_d;
  logic               idle_q,     idle_d;

  logic               crc_clear;
  logic               crc_shift;
  logic [6:0]         crc;
  logic [FRAME_W-1:0] new_frame;
  logic               err;
  status_e            err_code;
  logic               fin;
  status_e            fin_code;

  // Same engine serves both the outgoing frame and the incoming response.
  cmd_crc7 u_crc7 (
    .iClock_SD (iClock_SD),
    .iReset    (iReset),
    .clear_i   (crc_clear),
    .shift_i   (crc_shift),
    .data_i    (sh_q[39]),
    .crc_o     (crc)
  );

  always_comb begin
    state_d    = state_q;
    frame_d    = frame_q;
    sh_d       = sh_q;
    bit_cnt_d  = bit_cnt_q;
    retry_d    = retry_q;
    wd_d       = wd_q;
    rsp_exp_d  = rsp_exp_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    status_d   = status_q;
    response_d = response_q;
    strobe_d   = strobe_q;
    phy_ack_d  = 1'b0;
    idle_d     = idle_q;
    crc_clear  = 1'b0;
    crc_shift  = 1'b0;
    new_frame  = build_frame(iCmd_index, iCmd_argument);
    err        = 1'b0;
    err_code   = STAT_OK;
    fin        = 1'b0;
    fin_code   = STAT_OK;

    case (state_q)
      ST_IDLE: begin
        if (iNew_command) begin
          frame_d   = new_frame;
          sh_d      = new_frame[FRM_START:FRM_ARG_LO];
          rsp_exp_d = iRsp_expected;
          retry_d   = '0;
          bit_cnt_d = '0;
          busy_d    = 1'b1;
          idle_d    = 1'b0;
          crc_clear = 1'b1;
          state_d   = ST_CRC;
        end
      end

      ST_CRC: begin
        if (bit_cnt_q == CRC_BITS) begin
          frame_d[FRM_CRC_HI:FRM_CRC_LO] = crc;
          strobe_d = 1'b1;
          state_d  = ST_SEND;
        end else begin
          crc_shift = 1'b1;
          sh_d      = {sh_q[38:0], 1'b0};
          bit_cnt_d = bit_cnt_q + 6'd1;
        end
      end

      ST_SEND: begin
        if (phy.iPhy_ack) begin
          strobe_d = 1'b0;
          if (rsp_exp_q) begin
            wd_d    = '0;
            state_d = ST_WAIT_RSP;
          end else begin
            fin      = 1'b1;
            fin_code = STAT_OK;
          end
        end
      end

      ST_WAIT_RSP: begin
        // A response arriving together with a timeout takes priority.
        if (phy.iPhy_strobe) begin
          response_d = phy.iPhy_response;
          phy_ack_d  = 1'b1;
`ifdef CMD_RSP_CHECK_EN
          sh_d       = phy.iPhy_response[FRM_START:FRM_ARG_LO];
          bit_cnt_d  = '0;
          crc_clear  = 1'b1;
          state_d    = ST_CHECK;
`else
          fin        = 1'b1;
          fin_code   = STAT_OK;
`endif
        end else if (phy.iPhy_timeout) begin
          err      = 1'b1;
          err_code = STAT_TIMEOUT;
        end else if (wd_q == WD_LAST) begin
          err      = 1'b1;
          err_code = STAT_WATCHDOG;
        end else begin
          wd_d = wd_q + 16'd1;
        end
      end

`ifdef CMD_RSP_CHECK_EN
      ST_CHECK: begin
        if (bit_cnt_q == CRC_BITS) begin
          if (crc != response_q[FRM_CRC_HI:FRM_CRC_LO]) begin
            err      = 1'b1;
            err_code = STAT_CRC_ERR;
          end else if (response_q[FRM_IDX_HI:FRM_IDX_LO] != frame_q[FRM_IDX_HI:FRM_IDX_LO]) begin
            err      = 1'b1;
            err_code = STAT_INDEX_ERR;
          end else begin
            fin      = 1'b1;
            fin_code = STAT_OK;
          end
        end else begin
          crc_shift = 1'b1;
          sh_d      = {sh_q[38:0], 1'b0};
          bit_cnt_d = bit_cnt_q + 6'd1;
        end
      end
`endif

      ST_DONE: begin
        busy_d  = 1'b0;
        idle_d  = 1'b1;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Retries resend the frame already holding its CRC.
    if (err) begin
      if (retry_q < MAX_R) begin
        retry_d  = retry_q + 3'd1;
        strobe_d = 1'b1;
        state_d  = ST_SEND;
      end else begin
        fin      = 1'b1;
        fin_code = err_code;
      end
    end

    if (fin) begin
      state_d  = ST_DONE;
      done_d   = 1'b1;
      status_d = fin_code;
    end
  end

  always_ff @(posedge iClock_SD or posedge iReset) begin
    if (iReset) begin
      state_q    <= ST_IDLE;
      frame_q    <= '0;
      sh_q       <= '0;
      bit_cnt_q  <= '0;
      retry_q    <= '0;
      wd_q       <= '0;
      rsp_exp_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      status_q   <= '0;
      response_q <= '0;
      strobe_q   <= 1'b0;
      phy_ack_q  <= 1'b0;
      idle_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      frame_q    <= frame_d;
      sh_q       <= sh_d;
      bit_cnt_q  <= bit_cnt_d;
      retry_q    <= retry_d;
      wd_q       <= wd_d;
      rsp_exp_q  <= rsp_exp_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      status_q   <= status_d;
      response_q <= response_d;
      strobe_q   <= strobe_d;
      phy_ack_q  <= phy_ack_d;
      idle_q     <= idle_d;
    end
  end

  assign oBusy            = busy_q;
  assign oDone            = done_q;
  assign oStatus          = status_q;
  assign oResponse        = response_q;
  assign phy.oPhy_command = frame_q;
  assign phy.oPhy_strobe  = strobe_q;
  assign phy.oPhy_ack     = phy_ack_q;
  assign phy.oPhy_idle    = idle_q;

endmodule

// File: tb/tb_cmd_sequencer.sv
// Directed bench for cmd_sequencer: frame table plus handshake/retry/reset sequences.
module tb_cmd_sequencer;
  import cmd_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        new_cmd = 1'b0;
  logic [5:0]  cmd_idx = '0;
  logic [31:0] cmd_arg = '0;
  logic        rsp_exp = 1'b0;
  logic        busy, done;
  logic [2:0]  status;
  logic [47:0] response;

  always #5 clk = ~clk;

  cmd_sequencer_if phy ();

  cmd_sequencer #(.MAX_RETRIES(2), .WATCHDOG_CYCLES(16)) dut (
    .iClock_SD     (clk),
    .iReset        (rst),
    .iNew_command  (new_cmd),
    .iCmd_index    (cmd_idx),
    .iCmd_argument (cmd_arg),
    .iRsp_expected (rsp_exp),
    .oBusy         (busy),
    .oDone         (done),
    .oStatus       (status),
    .oResponse     (response),
    .phy           (phy)
  );

  typedef struct packed {
    logic [5:0]  idx;
    logic [31:0] arg;
    logic [47:0] frame;
  } vec_t;

  localparam logic [47:0] RSP_GOOD = 48'h08_0000_01AA_13;
  localparam logic [47:0] RSP_BAD  = 48'h08_0000_01AA_11;
  localparam logic [47:0] CMD8_FRM = 48'h48_0000_01AA_87;

`ifdef CMD_RSP_CHECK_EN
  localparam int          EXP_CHK_LAT   = 41;
  localparam int          EXP_BAD_TRIES = 2;
  localparam logic [47:0] EXP_BAD_RSP   = RSP_GOOD;
`else
  localparam int          EXP_CHK_LAT   = 0;
  localparam int          EXP_BAD_TRIES = 1;
  localparam logic [47:0] EXP_BAD_RSP   = RSP_BAD;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  // Per-attempt PHY behaviour: 0 respond, 1 timeout, 2 silent, 4 respond+timeout.
  int          modes   [4];
  logic [47:0] rsp_tbl [4];
  bit          spam = 1'b0;

  int          r_attempts, r_acks, r_done_cyc, r_ack_cyc;
  int          r_strobe_cyc [8];
  logic [47:0] r_frame;
  logic [2:0]  r_status;

  task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic run_cmd(input logic [5:0] idx, input logic [31:0] arg, input logic rexp);
    int  cyc;
    int  timer;
    int  m;
    bit  prev_strobe;
    r_attempts = 0; r_acks = 0; r_done_cyc = -1; r_ack_cyc = -1;
    r_frame = '0; r_status = '0;
    timer = -1; prev_strobe = 1'b0;
    for (int i = 0; i < 8; i++) r_strobe_cyc[i] = -1;
    @(negedge clk);
    cmd_idx = idx; cmd_arg = arg; rsp_exp = rexp; new_cmd = 1'b1;
    @(negedge clk);
    new_cmd = 1'b0;
    cyc = 0;
    while (r_done_cyc < 0 && cyc < 1000) begin
      @(negedge clk);
      cyc++;
      phy.iPhy_strobe  = 1'b0;
      phy.iPhy_timeout = 1'b0;
      if (phy.oPhy_ack) begin
        if (r_ack_cyc < 0) r_ack_cyc = cyc;
        r_acks++;
      end
      if (phy.oPhy_strobe && !prev_strobe) begin
        if (r_attempts < 8) r_strobe_cyc[r_attempts] = cyc;
        if (r_attempts == 0) r_frame = phy.oPhy_command;
        r_attempts++;
      end
      if (!phy.oPhy_strobe && prev_strobe && rexp) timer = 2;
      prev_strobe  = phy.oPhy_strobe;
      phy.iPhy_ack = phy.oPhy_strobe;
      if (done) begin
        r_done_cyc = cyc;
        r_status   = status;
      end
      m = (r_attempts > 0) ? r_attempts - 1 : 0;
      if (m > 3) m = 3;
      if (timer == 0) begin
        case (modes[m])
          0: begin phy.iPhy_strobe = 1'b1; phy.iPhy_response = rsp_tbl[m]; end
          1: phy.iPhy_timeout = 1'b1;
          4: begin phy.iPhy_strobe = 1'b1; phy.iPhy_timeout = 1'b1; phy.iPhy_response = rsp_tbl[m]; end
          default: ;
        endcase
      end
      if (timer >= 0) timer--;
      new_cmd = spam && (cyc % 5 == 0);
    end
    new_cmd = 1'b0; phy.iPhy_ack = 1'b0; phy.iPhy_strobe = 1'b0; phy.iPhy_timeout = 1'b0;
    if (r_done_cyc < 0) check("done_within_budget", 48'd0, 48'd1);
  endtask

  task automatic set_modes(input int m0, input int m1, input int m2,
                           input logic [47:0] p0, input logic [47:0] p1);
    modes[0] = m0; modes[1] = m1; modes[2] = m2; modes[3] = m2;
    rsp_tbl[0] = p0; rsp_tbl[1] = p1; rsp_tbl[2] = p1; rsp_tbl[3] = p1;
  endtask

  vec_t vecs [5];
  int   k;

  initial begin
    vecs[0] = '{idx: 6'd0,  arg: 32'h0000_0000, frame: 48'h40_0000_0000_95};
    vecs[1] = '{idx: 6'd55, arg: 32'h0000_0000, frame: 48'h77_0000_0000_65};
    vecs[2] = '{idx: 6'd41, arg: 32'h4000_0000, frame: 48'h69_4000_0000_77};
    vecs[3] = '{idx: 6'd1,  arg: 32'h0000_0000, frame: 48'h41_0000_0000_F9};
    vecs[4] = '{idx: 6'd8,  arg: 32'h0000_01AA, frame: CMD8_FRM};

    phy.iPhy_ack = 1'b0; phy.iPhy_strobe = 1'b0; phy.iPhy_timeout = 1'b0;
    phy.iPhy_response = '0;
    set_modes(0, 0, 0, RSP_GOOD, RSP_GOOD);

    repeat (3) @(negedge clk);
    check("rst_busy",   {47'd0, busy}, 48'd0);
    check("rst_done",   {47'd0, done}, 48'd0);
    check("rst_status", {45'd0, status}, 48'd0);
    check("rst_rsp",    response, 48'd0);
    check("rst_cmd",    phy.oPhy_command, 48'd0);
    check("rst_strobe", {47'd0, phy.oPhy_strobe}, 48'd0);
    check("rst_ack",    {47'd0, phy.oPhy_ack}, 48'd0);
    check("rst_idle",   {47'd0, phy.oPhy_idle}, 48'd1);
    rst = 1'b0;

    for (int i = 0; i < 5; i++) begin
      run_cmd(vecs[i].idx, vecs[i].arg, 1'b0);
      check($sformatf("tbl%0d_frame", i), r_frame, vecs[i].frame);
      check($sformatf("tbl%0d_status", i), {45'd0, r_status}, 48'd0);
      check($sformatf("tbl%0d_strobe_cyc", i), 48'(r_strobe_cyc[0]), 48'd41);
      check($sformatf("tbl%0d_done_cyc", i), 48'(r_done_cyc), 48'd42);
      check($sformatf("tbl%0d_no_rsp_ack", i), 48'(r_acks), 48'd0);
    end

    set_modes(0, 0, 0, RSP_GOOD, RSP_GOOD);
    run_cmd(6'd8, 32'h1AA, 1'b1);
    check("cmd8_frame",    r_frame, CMD8_FRM);
    check("cmd8_status",   {45'd0, r_status}, 48'd0);
    check("cmd8_rsp",      response, RSP_GOOD);
    check("cmd8_acks",     48'(r_acks), 48'd1);
    check("cmd8_tries",    48'(r_attempts), 48'd1);
    check("cmd8_chk_lat",  48'(r_done_cyc - r_ack_cyc), 48'(EXP_CHK_LAT));

    set_modes(1, 1, 1, RSP_GOOD, RSP_GOOD);
    run_cmd(6'd8, 32'h1AA, 1'b1);
    check("tmo_status", {45'd0, r_status}, 48'd1);
    check("tmo_tries",  48'(r_attempts), 48'd3);
    check("tmo_acks",   48'(r_acks), 48'd0);

    set_modes(4, 4, 4, RSP_GOOD, RSP_GOOD);
    run_cmd(6'd8, 32'h1AA, 1'b1);
    check("both_status", {45'd0, r_status}, 48'd0);
    check("both_tries",  48'(r_attempts), 48'd1);
    check("both_rsp",    response, RSP_GOOD);

    set_modes(0, 0, 0, RSP_BAD, RSP_GOOD);
    run_cmd(6'd8, 32'h1AA, 1'b1);
    check("crcretry_status", {45'd0, r_status}, 48'd0);
    check("crcretry_tries",  48'(r_attempts), 48'(EXP_BAD_TRIES));
    check("crcretry_rsp",    response, EXP_BAD_RSP);

    spam = 1'b1;
    set_modes(2, 2, 2, RSP_GOOD, RSP_GOOD);
    run_cmd(6'd8, 32'h1AA, 1'b1);
    spam = 1'b0;
    check("wd_status", {45'd0, r_status}, 48'd4);
    check("wd_tries",  48'(r_attempts), 48'd3);
    check("wd_gap1",   48'(r_strobe_cyc[1] - r_strobe_cyc[0]), 48'd17);
    check("wd_gap2",   48'(r_strobe_cyc[2] - r_strobe_cyc[1]), 48'd17);
    check("wd_last",   48'(r_done_cyc - r_strobe_cyc[2]), 48'd17);
    @(negedge clk);
    check("wd_idle_after_spam", {46'd0, busy, phy.oPhy_idle}, 48'd1);

    // Asynchronous reset while waiting for a response.
    @(negedge clk);
    cmd_idx = 6'd8; cmd_arg = 32'h1AA; rsp_exp = 1'b1; new_cmd = 1'b1;
    @(negedge clk);
    new_cmd = 1'b0;
    k = 0;
    while (!phy.oPhy_strobe && k < 100) begin @(negedge clk); k++; end
    check("arst_strobe_seen", {47'd0, phy.oPhy_strobe}, 48'd1);
    phy.iPhy_ack = 1'b1;
    @(negedge clk);
    phy.iPhy_ack = 1'b0;
    repeat (3) @(negedge clk);
    check("arst_pre_busy", {47'd0, busy}, 48'd1);
    #2 rst = 1'b1;
    #1;
    check("arst_strobe", {47'd0, phy.oPhy_strobe}, 48'd0);
    check("arst_busy",   {47'd0, busy}, 48'd0);
    check("arst_idle",   {47'd0, phy.oPhy_idle}, 48'd1);
    check("arst_cmd",    phy.oPhy_command, 48'd0);
    @(negedge clk);
    rst = 1'b0;

    set_modes(0, 0, 0, RSP_GOOD, RSP_GOOD);
    run_cmd(6'd8, 32'h1AA, 1'b1);
    check("post_rst_frame",  r_frame, CMD8_FRM);
    check("post_rst_status", {45'd0, r_status}, 48'd0);
    check("post_rst_rsp",    response, RSP_GOOD);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
